// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline sequencer for the 16-bit, 5-stage integer core (IF/ID/EX/MEM/WB).
//   It does three jobs:
//     - It detects load-use hazards between EX and ID and inserts a
//       one-cycle stall with a bubble into EX.
//     - It flushes the younger stages when EX resolves a taken jump or branch.
//     - It runs the interrupt entry and return sequence. The FSM drains the
//       pipe, saves the EPC, redirects the PC to the vector, and later
//       returns to the EPC.
//
// Ports
//   clk_i            core clock; all state updates on the rising edge
//   rst_ni           synchronous, active-low reset
//   id_valid_i       ID stage holds a real instruction
//   id_pc_i          PC of the instruction in ID
//   id_rs_i/id_rd_i  source fields of the ID instruction (rd is also read)
//   if_pc_i          PC currently held in IF. It is saved as the EPC when ID
//                    holds a bubble at interrupt entry.
//   ex_valid_i       EX stage holds a real instruction
//   ex_load_i        EX instruction is a load
//   ex_rd_i          destination register of the EX instruction
//   ex_jump_i        EX resolved a taken branch or jump
//   ex_isr_ret_i     EX instruction is return-from-interrupt
//   irq_i            level-sensitive interrupt requests; bit 0 has the
//                    highest priority
//   irq_mask_i       1 = source enabled
//   pc_stall_o       hold the PC
//   ifid_stall_o     hold the IF/ID register
//   ifid_flush_o     load a bubble into IF/ID
//   idex_flush_o     load a bubble into ID/EX
//   pc_redirect_o    PC <= redirect_addr_o on the next edge
//   redirect_addr_o  redirect target; 0 when no redirect is active
//   epc_o            saved return PC
//   int_active_o     handler in progress; further irqs are ignored
//   int_ack_o        one-hot, one-cycle acknowledge of the taken source
//   state_o          current FSM state (debug visibility)
//
// Handshake note: there is no valid/ready flow here. Each control output
// applies to the pipeline registers at the very next rising edge.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned IRQ_N     = 4,
  parameter int unsigned DRAIN_CYC = 2,        // legal range 1..7
  parameter logic [15:0] VEC_BASE  = 16'h0010
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [15:0]      id_pc_i,
  input  logic [2:0]       id_rs_i,
  input  logic [2:0]       id_rd_i,
  input  logic [15:0]      if_pc_i,
  input  logic             ex_valid_i,
  input  logic             ex_load_i,
  input  logic [2:0]       ex_rd_i,
  input  logic             ex_jump_i,
  input  logic             ex_isr_ret_i,
  input  logic [IRQ_N-1:0] irq_i,
  input  logic [IRQ_N-1:0] irq_mask_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             pc_redirect_o,
  output logic [15:0]      redirect_addr_o,
  output logic [15:0]      epc_o,
  output logic             int_active_o,
  output logic [IRQ_N-1:0] int_ack_o,
  output logic [2:0]       state_o
);

  localparam int unsigned IDX_W      = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
  localparam logic [2:0]  DRAIN_LOAD = 3'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_VECTOR = 3'd2,
    S_ISR    = 3'd3,
    S_RET    = 3'd4
  } state_e;

  // Lowest set bit wins, so source 0 has the highest priority.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [IRQ_N-1:0] v);
    lowest_idx = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      epc_q, epc_d;

  // Registered FSM outputs. Each is decoded from the next state, so it
  // matches the state it belongs to in the same cycle.
  logic             drain_q;
  logic             redirect_q;
  logic [15:0]      redirect_addr_q;
  logic [IRQ_N-1:0] int_ack_q;
  logic             int_active_q;

  logic [IRQ_N-1:0] pend_vec;
  logic             pending;
  logic             hazard_live;
  logic             load_use;
  logic             jump;
  logic             take_irq;
  logic             take_ret;
  logic             ctl_flush;
  logic             hz_stall;
  logic [15:0]      vec_addr_d;

  assign pend_vec = irq_i & irq_mask_i;
  assign pending  = |pend_vec;

  assign hazard_live = (state_q == S_IDLE) || (state_q == S_ISR);
  assign load_use    = ex_valid_i && ex_load_i && id_valid_i &&
                       ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rd_i));
  assign jump        = ex_valid_i && ex_jump_i;

  // A jump in the same cycle defers interrupt entry by one cycle. This way
  // the jump target reaches IF/ID and becomes the EPC, and is not lost.
  assign take_irq = (state_q == S_IDLE) && pending && !jump;
  assign take_ret = (state_q == S_ISR) && ex_valid_i && ex_isr_ret_i;

  // Any control transfer flushes IF/ID and ID/EX. Flushing removes the ID
  // instruction that a load-use stall would hold, so the stall is dropped.
  assign ctl_flush = hazard_live && (jump || take_irq || take_ret);
  assign hz_stall  = hazard_live && load_use && !ctl_flush;

  assign vec_addr_d = VEC_BASE + 16'({idx_d, 2'b00});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    epc_d   = epc_q;
    case (state_q)
      S_IDLE: begin
        if (take_irq) begin
          state_d = S_DRAIN;
          // A bubble in ID means the next instruction to run is the one in IF.
          epc_d   = id_valid_i ? id_pc_i : if_pc_i;
          idx_d   = lowest_idx(pend_vec);
          cnt_d   = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        // The counter is loaded with DRAIN_CYC-1, so the drain lasts
        // DRAIN_CYC cycles including the one where it reaches zero.
        if (cnt_q == 3'd0) state_d = S_VECTOR;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_VECTOR: state_d = S_ISR;
      S_ISR: begin
        if (take_ret) state_d = S_RET;
      end
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      cnt_q           <= 3'd0;
      idx_q           <= '0;
      epc_q           <= 16'h0000;
      drain_q         <= 1'b0;
      redirect_q      <= 1'b0;
      redirect_addr_q <= 16'h0000;
      int_ack_q       <= '0;
      int_active_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      epc_q        <= epc_d;
      drain_q      <= (state_d == S_DRAIN);
      redirect_q   <= (state_d == S_VECTOR) || (state_d == S_RET);
      int_active_q <= (state_d == S_ISR) || (state_d == S_RET);
      if (state_d == S_VECTOR)   redirect_addr_q <= vec_addr_d;
      else if (state_d == S_RET) redirect_addr_q <= epc_d;
      else                       redirect_addr_q <= 16'h0000;
      if (state_d == S_VECTOR)
        int_ack_q <= {{(IRQ_N-1){1'b0}}, 1'b1} << idx_d;
      else
        int_ack_q <= '0;
    end
  end

  // DRAIN holds the PC and keeps both front registers empty. VECTOR and RET
  // discard the IF/ID slot fetched from the old PC.
  assign pc_stall_o      = hz_stall | drain_q;
  assign ifid_stall_o    = hz_stall;
  assign ifid_flush_o    = ctl_flush | drain_q | redirect_q;
  assign idex_flush_o    = ctl_flush | hz_stall | drain_q;
  assign pc_redirect_o   = redirect_q;
  assign redirect_addr_o = redirect_addr_q;
  assign epc_o           = epc_q;
  assign int_active_o    = int_active_q;
  assign int_ack_o       = int_ack_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl.
// Each cycle the driver sets the inputs. A reference model then predicts the
// outputs for that cycle and pushes the prediction into exp_q. A monitor on
// the falling edge pops each prediction and compares it with the DUT.
// The model keeps the interrupt sequence as a schedule of upcoming actions:
// drain cycles, the vector cycle, and the return cycle.
module tb_pipe_ctrl;

  localparam int          IRQ_N     = 4;
  localparam int          DRAIN_CYC = 2;
  localparam logic [15:0] VEC_BASE  = 16'h0010;

  localparam int A_DRAIN  = 1;
  localparam int A_VECTOR = 2;
  localparam int A_RET    = 3;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [15:0]      id_pc;
  logic [2:0]       id_rs;
  logic [2:0]       id_rd;
  logic [15:0]      if_pc;
  logic             ex_valid;
  logic             ex_load;
  logic [2:0]       ex_rd;
  logic             ex_jump;
  logic             ex_isr_ret;
  logic [IRQ_N-1:0] irq;
  logic [IRQ_N-1:0] irq_mask;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pc_redirect;
  logic [15:0]      redirect_addr;
  logic [15:0]      epc;
  logic             int_active;
  logic [IRQ_N-1:0] int_ack;
  logic [2:0]       state_dbg;

  pipe_ctrl #(
    .IRQ_N    (IRQ_N),
    .DRAIN_CYC(DRAIN_CYC),
    .VEC_BASE (VEC_BASE)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .id_valid_i     (id_valid),
    .id_pc_i        (id_pc),
    .id_rs_i        (id_rs),
    .id_rd_i        (id_rd),
    .if_pc_i        (if_pc),
    .ex_valid_i     (ex_valid),
    .ex_load_i      (ex_load),
    .ex_rd_i        (ex_rd),
    .ex_jump_i      (ex_jump),
    .ex_isr_ret_i   (ex_isr_ret),
    .irq_i          (irq),
    .irq_mask_i     (irq_mask),
    .pc_stall_o     (pc_stall),
    .ifid_stall_o   (ifid_stall),
    .ifid_flush_o   (ifid_flush),
    .idex_flush_o   (idex_flush),
    .pc_redirect_o  (pc_redirect),
    .redirect_addr_o(redirect_addr),
    .epc_o          (epc),
    .int_active_o   (int_active),
    .int_ack_o      (int_ack),
    .state_o        (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic             chk;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_flush;
    logic             pc_redirect;
    logic [15:0]      redirect_addr;
    logic [15:0]      epc;
    logic             int_active;
    logic [IRQ_N-1:0] int_ack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // ---------------- reference model ----------------
  int          script[$];
  bit          m_in_handler;
  logic [15:0] m_epc;
  int          m_idx;

  task automatic model_cycle();
    exp_t e;
    int   act;
    bit   jmp, lu, enter, leave;
    logic [IRQ_N-1:0] pend;
    e = '0;
    if (!rst_n) begin
      // Outputs in the reset cycle are not checked. The edge clears everything.
      e.chk = 1'b0;
      script.delete();
      m_in_handler = 1'b0;
      m_epc = 16'h0000;
      m_idx = 0;
      exp_q.push_back(e);
      return;
    end
    e.chk = 1'b1;
    e.epc = m_epc;
    if (script.size() != 0) begin
      act = script.pop_front();
      if (act == A_DRAIN) begin
        e.pc_stall = 1'b1; e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
      end else if (act == A_VECTOR) begin
        e.pc_redirect   = 1'b1;
        e.redirect_addr = VEC_BASE + 16'(4 * m_idx);
        e.int_ack       = IRQ_N'(1 << m_idx);
        e.ifid_flush    = 1'b1;
        m_in_handler    = 1'b1;
      end else begin
        e.pc_redirect   = 1'b1;
        e.redirect_addr = m_epc;
        e.int_active    = 1'b1;
        e.ifid_flush    = 1'b1;
        m_in_handler    = 1'b0;
      end
    end else begin
      pend  = irq & irq_mask;
      jmp   = ex_valid && ex_jump;
      lu    = ex_valid && ex_load && id_valid && (ex_rd == id_rs || ex_rd == id_rd);
      enter = !m_in_handler && (pend != 0) && !jmp;
      leave = m_in_handler && ex_valid && ex_isr_ret;
      e.int_active = m_in_handler;
      if (jmp || enter || leave) begin
        e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
      end else if (lu) begin
        e.pc_stall = 1'b1; e.ifid_stall = 1'b1; e.idex_flush = 1'b1;
      end
      if (enter) begin
        m_epc = id_valid ? id_pc : if_pc;
        m_idx = -1;
        for (int i = 0; i < IRQ_N; i++) if (pend[i] && m_idx < 0) m_idx = i;
        repeat (DRAIN_CYC) script.push_back(A_DRAIN);
        script.push_back(A_VECTOR);
      end
      if (leave) script.push_back(A_RET);
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic quiet();
    rst_n = 1'b1; id_valid = 1'b0; id_pc = 16'h0000; id_rs = 3'd0; id_rd = 3'd0;
    if_pc = 16'h0000; ex_valid = 1'b0; ex_load = 1'b0; ex_rd = 3'd0;
    ex_jump = 1'b0; ex_isr_ret = 1'b0; irq = '0; irq_mask = '0;
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_use_pair(input logic [2:0] r, input logic use_rd);
    quiet();
    ex_valid = 1'b1; ex_load = 1'b1; ex_rd = r; id_valid = 1'b1; id_pc = 16'h0100;
    if (use_rd) begin id_rd = r; id_rs = r + 3'd1; end
    else        begin id_rs = r; id_rd = r + 3'd1; end
    step();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin quiet(); step(); end
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("pc_stall",      16'(pc_stall),      16'(e.pc_stall));
          check("ifid_stall",    16'(ifid_stall),    16'(e.ifid_stall));
          check("ifid_flush",    16'(ifid_flush),    16'(e.ifid_flush));
          check("idex_flush",    16'(idex_flush),    16'(e.idex_flush));
          check("pc_redirect",   16'(pc_redirect),   16'(e.pc_redirect));
          check("redirect_addr", redirect_addr,      e.redirect_addr);
          check("epc",           epc,                e.epc);
          check("int_active",    16'(int_active),    16'(e.int_active));
          check("int_ack",       16'(int_ack),       16'(e.int_ack));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    quiet();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    quiet();
    // The cycle after reset: everything is 0, including epc.
    step();

    // Load-use on rs, then on rd, each released after one cycle.
    load_use_pair(3'd3, 1'b0);
    idle_cycles(1);
    load_use_pair(3'd5, 1'b1);
    idle_cycles(1);
    // Same destination, but EX is not a load: no stall.
    load_use_pair(3'd3, 1'b0); ex_load = 1'b0; // takes effect next step
    step();

    // A jump beats load-use.
    load_use_pair(3'd3, 1'b0); // stall cycle
    quiet();
    ex_valid = 1'b1; ex_load = 1'b1; ex_rd = 3'd3; id_valid = 1'b1; id_rs = 3'd3;
    ex_jump = 1'b1;
    step();
    idle_cycles(1);

    // Interrupt entry: source 1 wins over source 2, epc = 0x0042, vector 0x0014.
    quiet();
    irq = 4'b0110; irq_mask = 4'hF; id_valid = 1'b1; id_pc = 16'h0042;
    step();
    quiet();              // irq drops after entry; the sequence continues
    idle_cycles(4);       // DRAIN x2, VECTOR, first ISR cycle

    // In ISR, all requests are ignored; hazard logic is still live.
    for (int i = 0; i < 3; i++) begin
      quiet(); irq = 4'hF; irq_mask = 4'hF; step();
    end
    load_use_pair(3'd2, 1'b0);
    quiet(); ex_valid = 1'b1; ex_jump = 1'b1; step();

    // Return from interrupt -> RET redirects to epc -> IDLE.
    quiet(); ex_valid = 1'b1; ex_isr_ret = 1'b1; step();
    idle_cycles(3);

    // A masked request does nothing.
    for (int i = 0; i < 3; i++) begin
      quiet(); irq = 4'b0001; irq_mask = 4'b0000; step();
    end
    // ex_isr_ret outside ISR is ignored.
    quiet(); ex_valid = 1'b1; ex_isr_ret = 1'b1; step();

    // Entry with ID empty saves the IF PC. Reset mid-DRAIN.
    quiet(); irq = 4'b1000; irq_mask = 4'b1000; if_pc = 16'h0BEE; step();
    quiet(); step();                       // first DRAIN cycle
    quiet(); rst_n = 1'b0; step();         // reset sampled
    idle_cycles(3);

    // irq together with a jump: entry happens one cycle later.
    quiet(); irq = 4'b0100; irq_mask = 4'hF; ex_valid = 1'b1; ex_jump = 1'b1;
    id_valid = 1'b1; id_pc = 16'h0033; step();
    quiet(); irq = 4'b0100; irq_mask = 4'hF; id_valid = 1'b1; id_pc = 16'h0077; step();
    idle_cycles(5);
    quiet(); ex_valid = 1'b1; ex_isr_ret = 1'b1; step();
    idle_cycles(2);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      quiet();
      rst_n      = ($urandom_range(0, 199) != 0);
      id_valid   = 1'($urandom_range(0, 1));
      id_pc      = 16'($urandom);
      if_pc      = 16'($urandom);
      ex_rd      = 3'($urandom_range(0, 7));
      id_rs      = ($urandom_range(0, 2) == 0) ? ex_rd : 3'($urandom_range(0, 7));
      id_rd      = ($urandom_range(0, 3) == 0) ? ex_rd : 3'($urandom_range(0, 7));
      ex_valid   = ($urandom_range(0, 3) != 0);
      ex_load    = 1'($urandom_range(0, 1));
      ex_jump    = ($urandom_range(0, 4) == 0);
      ex_isr_ret = ($urandom_range(0, 9) == 0);
      irq        = ($urandom_range(0, 9) == 0) ? IRQ_N'($urandom) : '0;
      irq_mask   = IRQ_N'($urandom);
      step();
    end

    quiet();
    step();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
